int_ctrl_vec: RTL and testbench

- Parametrised vectored interrupt controller in front of the multi-cycle CPU core.
- Replaces the single raw EX_irq/EX_fiq pair and externally driven INT_Vector with N_SRC synchronised sources.
- Per-source enable, IRQ/FIQ class select and edge/level mode; fixed priority with nesting.
- Generates INT_irq, INT_fiq and INT_Vector for the core and tracks in-service state through an ack/EOI handshake.

---
 rtl/int_ctrl_vec.sv | 177 +++++++++++++++++
 tb/tb_int_ctrl_vec.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl_vec.sv
// -----------------------------------------------------------------------------
// int_ctrl_vec -- vectored interrupt controller for the multi-cycle CPU core.
//
// Takes N_SRC asynchronous interrupt lines, synchronises them and keeps a
// pending register. Each source has its own enable, IRQ/FIQ class select and
// edge/level mode. The controller picks a fixed-priority winner for each
// class (index 0 is highest) and presents INT_irq / INT_fiq with a vector to
// the core. It tracks in-service state through the ack / EOI handshake, so a
// higher-priority IRQ can nest over a lower one. FIQ never nests.
//
// Ports
//   clk           system clock, rising edge
//   Rst           asynchronous reset, active low
//   src_in        raw interrupt lines, active high
//   cfg_we        one-cycle config write strobe
//   cfg_addr      0=ENABLE 1=FIQ_SEL 2=EDGE_MODE 3=PEND_CLR (write-1-to-clear)
//   cfg_wdata     config write data
//   irq_ack       CPU pulse, IRQ entry taken
//   fiq_ack       CPU pulse, FIQ entry taken (wins over irq_ack)
//   eoi           CPU pulse, end of interrupt
//   eoi_fiq       class of eoi (1=FIQ, 0=IRQ)
//   INT_irq       registered IRQ request
//   INT_fiq       registered FIQ request
//   INT_Vector    registered vector of the presented request
//   irq_id        source id behind INT_irq
//   fiq_id        source id behind INT_fiq
//   pending_o     pending register
//   in_service_o  in-service register (both classes)
// -----------------------------------------------------------------------------
module int_ctrl_vec #(
    parameter int unsigned       N_SRC      = 8,
    parameter int unsigned       VEC_W      = 32,
    parameter logic [VEC_W-1:0]  IRQ_BASE   = 32'h0000_0020,
    parameter logic [VEC_W-1:0]  FIQ_BASE   = 32'h0000_0040,
    parameter int unsigned       VEC_STRIDE = 4
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] src_in,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [N_SRC-1:0] cfg_wdata,
    input  logic             irq_ack,
    input  logic             fiq_ack,
    input  logic             eoi,
    input  logic             eoi_fiq,
    output logic             INT_irq,
    output logic             INT_fiq,
    output logic [VEC_W-1:0] INT_Vector,
    output logic [4:0]       irq_id,
    output logic [4:0]       fiq_id,
    output logic [N_SRC-1:0] pending_o,
    output logic [N_SRC-1:0] in_service_o
);

    localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [4:0] lowest_idx(input logic [N_SRC-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = i[4:0];
        end
        return idx;
    endfunction

    logic [N_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [N_SRC-1:0] en_q, sel_q, edge_q, pend_q;
    logic [N_SRC-1:0] en_d, sel_d, edge_d, pend_d;
    // In-service state is kept per class so later FIQ_SEL edits cannot
    // move a source that is already being serviced into the other class.
    logic [N_SRC-1:0] isv_irq_q, isv_fiq_q, isv_irq_d, isv_fiq_d;
    logic             int_irq_q, int_fiq_q;
    logic [4:0]       irq_id_q, fiq_id_q, irq_id_d, fiq_id_d;
    logic [VEC_W-1:0] vec_q, vec_d;

    logic             ack_fiq_ok, ack_irq_ok;
    logic [N_SRC-1:0] fiq_ack_mask, irq_ack_mask, ack_mask;
    logic [N_SRC-1:0] eoi_fiq_mask, eoi_irq_mask;
    logic [N_SRC-1:0] rise, pend_clr, pend_eff;
    logic [N_SRC-1:0] fiq_cand, irq_cand;
    logic [4:0]       fiq_win, irq_win, isv_irq_low;
    logic             fiq_elig, irq_elig;

    always_comb begin
        // Acks only count while the matching request is up; fiq_ack wins.
        ack_fiq_ok   = fiq_ack & int_fiq_q;
        ack_irq_ok   = irq_ack & int_irq_q & ~fiq_ack;
        fiq_ack_mask = ack_fiq_ok ? (ONE << fiq_id_q) : '0;
        irq_ack_mask = ack_irq_ok ? (ONE << irq_id_q) : '0;
        ack_mask     = fiq_ack_mask | irq_ack_mask;

        // v & -v isolates the lowest set bit; an empty class yields 0,
        // so a stray EOI is naturally ignored.
        eoi_fiq_mask = (eoi & eoi_fiq)  ? (isv_fiq_q & (~isv_fiq_q + ONE)) : '0;
        eoi_irq_mask = (eoi & ~eoi_fiq) ? (isv_irq_q & (~isv_irq_q + ONE)) : '0;
        isv_fiq_d    = (isv_fiq_q & ~eoi_fiq_mask) | fiq_ack_mask;
        isv_irq_d    = (isv_irq_q & ~eoi_irq_mask) | irq_ack_mask;

        // Edge sources: new edge beats a same-cycle clear. Level: follow line.
        rise     = sync2_q & ~prev_q;
        pend_clr = ack_mask | ((cfg_we && cfg_addr == 2'd3) ? cfg_wdata : '0);
        pend_d   = (edge_q & ((pend_q & ~pend_clr) | rise)) | (~edge_q & sync2_q);

        en_d  = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : en_q;
        sel_d = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : sel_q;
        edge_d = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : edge_q;

        // Arbitrate on the state as it will be after this cycle's ack/EOI,
        // so a request drops on the edge that takes the ack and the next
        // eligible source is presented at that same edge.
        pend_eff    = pend_q & ~(ack_mask & edge_q);
        fiq_cand    = pend_eff & en_q & sel_q;
        irq_cand    = pend_eff & en_q & ~sel_q;
        fiq_win     = lowest_idx(fiq_cand);
        irq_win     = lowest_idx(irq_cand);
        isv_irq_low = lowest_idx(isv_irq_d);

        fiq_elig = (|fiq_cand) & ~(|isv_fiq_d);
        irq_elig = (|irq_cand) & ~(|isv_fiq_d) & ~fiq_elig &
                   (~(|isv_irq_d) | (irq_win < isv_irq_low));

        fiq_id_d = fiq_elig ? fiq_win : fiq_id_q;
        irq_id_d = irq_elig ? irq_win : irq_id_q;
        if (fiq_elig) begin
            vec_d = FIQ_BASE + VEC_W'(fiq_win) * VEC_W'(VEC_STRIDE);
        end else if (irq_elig) begin
            vec_d = IRQ_BASE + VEC_W'(irq_win) * VEC_W'(VEC_STRIDE);
        end else begin
            vec_d = vec_q;
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            en_q      <= '0;
            sel_q     <= '0;
            edge_q    <= '0;
            pend_q    <= '0;
            isv_irq_q <= '0;
            isv_fiq_q <= '0;
            int_irq_q <= 1'b0;
            int_fiq_q <= 1'b0;
            irq_id_q  <= '0;
            fiq_id_q  <= '0;
            vec_q     <= '0;
        end else begin
            sync1_q   <= src_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            en_q      <= en_d;
            sel_q     <= sel_d;
            edge_q    <= edge_d;
            pend_q    <= pend_d;
            isv_irq_q <= isv_irq_d;
            isv_fiq_q <= isv_fiq_d;
            int_irq_q <= irq_elig;
            int_fiq_q <= fiq_elig;
            irq_id_q  <= irq_id_d;
            fiq_id_q  <= fiq_id_d;
            vec_q     <= vec_d;
        end
    end

    assign INT_irq      = int_irq_q;
    assign INT_fiq      = int_fiq_q;
    assign INT_Vector   = vec_q;
    assign irq_id       = irq_id_q;
    assign fiq_id       = fiq_id_q;
    assign pending_o    = pend_q;
    assign in_service_o = isv_irq_q | isv_fiq_q;

endmodule

// File: tb/tb_int_ctrl_vec.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl_vec -- directed bench for int_ctrl_vec with hand-computed
// expectations. Inputs change and outputs are sampled 1 ns after the rising
// edge.
// -----------------------------------------------------------------------------
module tb_int_ctrl_vec;

    logic        clk;
    logic        Rst;
    logic [7:0]  src_in;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        irq_ack, fiq_ack, eoi, eoi_fiq;
    logic        INT_irq, INT_fiq;
    logic [31:0] INT_Vector;
    logic [4:0]  irq_id, fiq_id;
    logic [7:0]  pending_o, in_service_o;

    int n_cmp = 0;
    int n_err = 0;

    int_ctrl_vec dut (
        .clk          (clk),
        .Rst          (Rst),
        .src_in       (src_in),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .irq_ack      (irq_ack),
        .fiq_ack      (fiq_ack),
        .eoi          (eoi),
        .eoi_fiq      (eoi_fiq),
        .INT_irq      (INT_irq),
        .INT_fiq      (INT_fiq),
        .INT_Vector   (INT_Vector),
        .irq_id       (irq_id),
        .fiq_id       (fiq_id),
        .pending_o    (pending_o),
        .in_service_o (in_service_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("  ok %s = %h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic do_irq_ack();
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    endtask

    task automatic do_fiq_ack();
        fiq_ack = 1'b1; tick(1); fiq_ack = 1'b0;
    endtask

    task automatic do_eoi(input logic f);
        eoi = 1'b1; eoi_fiq = f; tick(1); eoi = 1'b0; eoi_fiq = 1'b0;
    endtask

    // One-cycle pulse on src_in; returns right after the synchronised edge
    // has become a request (edge 4 after the rising edge of src_in).
    task automatic pulse_to_req(input logic [7:0] s);
        src_in = s; tick(1); src_in = '0; tick(3);
    endtask

    initial begin
        Rst = 1'b1; src_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        irq_ack = 1'b0; fiq_ack = 1'b0; eoi = 1'b0; eoi_fiq = 1'b0;
        #1 Rst = 1'b0;
        #2;
        chk("rst_int_irq", {31'd0, INT_irq}, 32'd0);
        chk("rst_int_fiq", {31'd0, INT_fiq}, 32'd0);
        chk("rst_vector", INT_Vector, 32'd0);
        chk("rst_pending", {24'd0, pending_o}, 32'd0);
        chk("rst_in_service", {24'd0, in_service_o}, 32'd0);
        @(posedge clk); #1 Rst = 1'b1;
        tick(1);

        // ---- basic edge IRQ on source 0 ----
        cfg_write(2'd0, 8'h01);
        cfg_write(2'd2, 8'h01);
        src_in = 8'h01; tick(2); src_in = '0; tick(1);
        chk("s1_pending_edge3", {24'd0, pending_o}, 32'h01);
        chk("s1_irq_edge3", {31'd0, INT_irq}, 32'd0);
        tick(1);
        chk("s1_irq_edge4", {31'd0, INT_irq}, 32'd1);
        chk("s1_vector", INT_Vector, 32'h20);
        chk("s1_irq_id", {27'd0, irq_id}, 32'd0);
        do_irq_ack();
        chk("s1_irq_after_ack", {31'd0, INT_irq}, 32'd0);
        chk("s1_isv_after_ack", {24'd0, in_service_o}, 32'h01);
        chk("s1_pend_after_ack", {24'd0, pending_o}, 32'h00);
        do_eoi(1'b0);
        chk("s1_isv_after_eoi", {24'd0, in_service_o}, 32'h00);
        do_irq_ack();   // INT_irq low: must be ignored
        chk("s1_stray_ack", {24'd0, in_service_o}, 32'h00);

        // ---- FIQ beats IRQ; FIQ in service blocks IRQ ----
        cfg_write(2'd1, 8'h04);
        cfg_write(2'd0, 8'h05);
        cfg_write(2'd2, 8'h05);
        pulse_to_req(8'h05);
        chk("s2_int_fiq", {31'd0, INT_fiq}, 32'd1);
        chk("s2_fiq_vector", INT_Vector, 32'h48);
        chk("s2_fiq_id", {27'd0, fiq_id}, 32'd2);
        chk("s2_int_irq_blocked", {31'd0, INT_irq}, 32'd0);
        do_fiq_ack();
        chk("s2_fiq_after_ack", {31'd0, INT_fiq}, 32'd0);
        chk("s2_isv_fiq", {24'd0, in_service_o}, 32'h04);
        tick(2);
        chk("s2_irq_held_off", {31'd0, INT_irq}, 32'd0);
        do_eoi(1'b1);
        chk("s2_irq_after_feoi", {31'd0, INT_irq}, 32'd1);
        chk("s2_irq_vector", INT_Vector, 32'h20);
        chk("s2_isv_after_feoi", {24'd0, in_service_o}, 32'h00);
        do_irq_ack();
        do_eoi(1'b0);

        // ---- IRQ nesting ----
        cfg_write(2'd1, 8'h00);
        cfg_write(2'd0, 8'h2A);
        cfg_write(2'd2, 8'h2A);
        pulse_to_req(8'h08);
        chk("s3_irq_src3", {31'd0, INT_irq}, 32'd1);
        chk("s3_vec_src3", INT_Vector, 32'h2C);
        do_irq_ack();
        chk("s3_isv_src3", {24'd0, in_service_o}, 32'h08);
        pulse_to_req(8'h02);
        chk("s3_nest_irq", {31'd0, INT_irq}, 32'd1);
        chk("s3_nest_id", {27'd0, irq_id}, 32'd1);
        chk("s3_nest_vec", INT_Vector, 32'h24);
        do_irq_ack();
        chk("s3_isv_nested", {24'd0, in_service_o}, 32'h0A);
        do_eoi(1'b0);
        chk("s3_eoi_lowest", {24'd0, in_service_o}, 32'h08);
        pulse_to_req(8'h20);
        chk("s3_low_prio_blocked", {31'd0, INT_irq}, 32'd0);
        chk("s3_low_prio_pending", {24'd0, pending_o}, 32'h20);
        do_eoi(1'b0);
        chk("s3_low_prio_after_eoi", {31'd0, INT_irq}, 32'd1);
        chk("s3_low_prio_vec", INT_Vector, 32'h34);
        do_irq_ack();
        do_eoi(1'b0);
        chk("s3_isv_clean", {24'd0, in_service_o}, 32'h00);

        // ---- level mode on source 4 ----
        cfg_write(2'd2, 8'h00);
        cfg_write(2'd0, 8'h10);
        src_in = 8'h10; tick(4);
        chk("s4_level_irq", {31'd0, INT_irq}, 32'd1);
        chk("s4_level_vec", INT_Vector, 32'h30);
        do_irq_ack();
        chk("s4_irq_after_ack", {31'd0, INT_irq}, 32'd0);
        chk("s4_pend_kept", {24'd0, pending_o}, 32'h10);
        do_eoi(1'b0);
        chk("s4_reassert", {31'd0, INT_irq}, 32'd1);
        src_in = '0; tick(2);
        chk("s4_pend_edge2", {24'd0, pending_o}, 32'h10);
        tick(1);
        chk("s4_pend_edge3", {24'd0, pending_o}, 32'h00);
        tick(1);
        chk("s4_irq_dropped", {31'd0, INT_irq}, 32'd0);

        // ---- disabled source latches; PEND_CLR vs new edge ----
        cfg_write(2'd0, 8'h00);
        cfg_write(2'd2, 8'h40);
        pulse_to_req(8'h40);
        chk("s5_pend_disabled", {24'd0, pending_o}, 32'h40);
        chk("s5_irq_disabled", {31'd0, INT_irq}, 32'd0);
        cfg_write(2'd0, 8'h40);
        tick(1);
        chk("s5_irq_enabled", {31'd0, INT_irq}, 32'd1);
        chk("s5_vec_enabled", INT_Vector, 32'h38);
        src_in = 8'h40; tick(1); src_in = '0; tick(1);
        cfg_write(2'd3, 8'h40);   // clear lands on the same edge as the rise
        chk("s5_set_beats_clr", {24'd0, pending_o}, 32'h40);
        cfg_write(2'd3, 8'h40);
        chk("s5_pend_clr", {24'd0, pending_o}, 32'h00);
        tick(1);
        chk("s5_irq_after_clr", {31'd0, INT_irq}, 32'd0);

        // ---- async reset in the middle of service ----
        cfg_write(2'd1, 8'h02);
        cfg_write(2'd0, 8'h03);
        cfg_write(2'd2, 8'h03);
        pulse_to_req(8'h01);
        do_irq_ack();
        pulse_to_req(8'h02);
        chk("s6_fiq_up", {31'd0, INT_fiq}, 32'd1);
        chk("s6_isv_up", {24'd0, in_service_o}, 32'h01);
        #2 Rst = 1'b0;
        #1;
        chk("s6_rst_int_fiq", {31'd0, INT_fiq}, 32'd0);
        chk("s6_rst_int_irq", {31'd0, INT_irq}, 32'd0);
        chk("s6_rst_vector", INT_Vector, 32'd0);
        chk("s6_rst_fiq_id", {27'd0, fiq_id}, 32'd0);
        chk("s6_rst_isv", {24'd0, in_service_o}, 32'd0);
        chk("s6_rst_pending", {24'd0, pending_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
